// File: rtl/fpga_klut_cfg.sv
// K-input configurable LUT cell with a serially loaded shadow configuration.
// A new truth table and mode bit shift into a shadow register while the active
// table keeps evaluating; a one-cycle commit then copies the shadow into the
// active table. The mode bit selects a combinational or clock-enabled registered
// output.
module fpga_klut_cfg #(
  parameter int unsigned K = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         cfg_en_i,
  input  logic         cfg_bit_i,
  output logic         cfg_busy_o,
  output logic         cfg_done_o,
  input  logic [K-1:0] in_i,
  input  logic         ce_i,
  output logic         out_o
);

  // Truth-table width and per-cell bitstream length (table plus mode bit).
  localparam int unsigned TblW   = 2 ** K;
  localparam int unsigned CfgLen = TblW + 1;
  localparam int unsigned CntW   = $clog2(CfgLen + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CfgLen-1:0] sh_q, sh_d;
  logic [TblW-1:0]   tbl_q, tbl_d;
  logic              mode_q, mode_d;
  logic              q_q, q_d;
  logic              done_q, done_d;
  logic              lut;

  // Active-table lookup; the shadow register never feeds this path.
  always_comb begin
    lut = tbl_q[in_i];
  end

  // Configuration FSM: shift into the shadow, then commit for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tbl_d   = tbl_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (cfg_en_i) begin
          sh_d    = {cfg_bit_i, sh_q[CfgLen-1:1]};
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        // Pauses (cfg_en_i low) hold both the shadow and the count.
        if (cfg_en_i) begin
          sh_d  = {cfg_bit_i, sh_q[CfgLen-1:1]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(CfgLen - 1)) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        // Strobes here are dropped; the driver must leave this cycle empty.
        tbl_d   = sh_q[TblW-1:0];
        mode_d  = sh_q[CfgLen-1];
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output flop tracks the lookup whenever enabled, in either mode, so a
  // switch to registered mode shows an up-to-date value.
  always_comb begin
    q_d = ce_i ? lut : q_q;
  end

  // All state, with synchronous reset overriding every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      tbl_q   <= '0;
      mode_q  <= 1'b0;
      q_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tbl_q   <= tbl_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  // Status decodes straight from registered state; output mux by mode.
  always_comb begin
    cfg_busy_o = (state_q != StIdle);
    cfg_done_o = done_q;
    out_o      = mode_q ? q_q : lut;
  end

endmodule

// File: tb/tb_fpga_klut_cfg.sv
// Self-checking bench for fpga_klut_cfg with K=4: expected outputs are queued
// when stimulus is applied and popped when the DUT response is sampled.
module tb_fpga_klut_cfg;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       cfg_en_i = 1'b0;
  logic       cfg_bit_i = 1'b0;
  logic       cfg_busy_o;
  logic       cfg_done_o;
  logic [3:0] in_i = 4'h0;
  logic       ce_i = 1'b0;
  logic       out_o;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic exp_v;

  fpga_klut_cfg #(.K(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .cfg_en_i   (cfg_en_i),
    .cfg_bit_i  (cfg_bit_i),
    .cfg_busy_o (cfg_busy_o),
    .cfg_done_o (cfg_done_o),
    .in_i       (in_i),
    .ce_i       (ce_i),
    .out_o      (out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Sweep in_i and compare the combinational output against table_v.
  task automatic sweep(input logic [15:0] table_v, input string name);
    for (int i = 0; i < 16; i++) begin
      in_i = 4'(i);
      exp_q.push_back(table_v[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out_o !== exp_v) begin
        errors++;
        $display("FAIL %s in=%0h: out_o=%b, want %b", name, i, out_o, exp_v);
      end
    end
  endtask

  // Shift {mode, table} LSB first; gap inserts an idle cycle between strobes.
  // old_out is what out_o must keep showing until the new config commits.
  task automatic load_cfg(input logic [15:0] table_v, input logic mode_v, input bit gap,
                          input logic old_out);
    logic [16:0] bits;
    bits = {mode_v, table_v};
    for (int i = 0; i < 17; i++) begin
      cfg_en_i  = 1'b1;
      cfg_bit_i = bits[i];
      tick();
      cfg_en_i = 1'b0;
      checks++;
      if (cfg_busy_o !== 1'b1 || cfg_done_o !== 1'b0) begin
        errors++;
        $display("FAIL load_status bit %0d: busy=%b done=%b, want busy=1 done=0",
                 i, cfg_busy_o, cfg_done_o);
      end
      exp_q.push_back(old_out);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_o !== exp_v) begin
        errors++;
        $display("FAIL load_out bit %0d: out_o=%b, want %b", i, out_o, exp_v);
      end
      if (gap && i < 16) begin
        tick();
        checks++;
        if (cfg_busy_o !== 1'b1 || cfg_done_o !== 1'b0) begin
          errors++;
          $display("FAIL load_pause bit %0d: busy=%b done=%b, want busy=1 done=0",
                   i, cfg_busy_o, cfg_done_o);
        end
      end
    end
    // COMMIT edge: next cycle carries the done pulse.
    tick();
    checks++;
    if (cfg_busy_o !== 1'b0 || cfg_done_o !== 1'b1) begin
      errors++;
      $display("FAIL load_done: busy=%b done=%b, want busy=0 done=1", cfg_busy_o, cfg_done_o);
    end
  endtask

  task automatic test_reset;
    reset_i  = 1'b1;
    cfg_en_i = 1'b1;
    cfg_bit_i = 1'b1;
    repeat (2) tick();
    reset_i  = 1'b0;
    cfg_en_i = 1'b0;
    checks++;
    if (cfg_busy_o !== 1'b0 || cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b, want 0 0", cfg_busy_o, cfg_done_o);
    end
    sweep(16'h0000, "reset_out");
    tick();
    checks++;
    if (cfg_busy_o !== 1'b0 || cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_status: busy=%b done=%b, want 0 0", cfg_busy_o, cfg_done_o);
    end
  endtask

  task automatic test_and4;
    ce_i = 1'b0;
    in_i = 4'h0;
    load_cfg(16'h8000, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b, want 0", cfg_done_o);
    end
    sweep(16'h8000, "and4");
  endtask

  task automatic test_xor_reg;
    ce_i = 1'b0;
    in_i = 4'h0;
    load_cfg(16'h6996, 1'b1, 1'b0, 1'b0);
    ce_i = 1'b1;
    in_i = 4'h1;
    #1;
    checks++;
    if (out_o !== 1'b0) begin
      errors++;
      $display("FAIL xor_reg_before_edge: out_o=%b, want 0", out_o);
    end
    tick();
    checks++;
    if (out_o !== 1'b1) begin
      errors++;
      $display("FAIL xor_reg_sample: out_o=%b, want 1", out_o);
    end
    ce_i = 1'b0;
    in_i = 4'h3;
    tick();
    checks++;
    if (out_o !== 1'b1) begin
      errors++;
      $display("FAIL xor_reg_hold: out_o=%b, want 1", out_o);
    end
    ce_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 1'b0) begin
      errors++;
      $display("FAIL xor_reg_enable: out_o=%b, want 0", out_o);
    end
    ce_i = 1'b0;
  endtask

  task automatic test_paused_load;
    in_i = 4'h5;
    load_cfg(16'hFFFF, 1'b0, 1'b0, 1'b0);
    load_cfg(16'h0000, 1'b0, 1'b1, 1'b1);
    checks++;
    if (out_o !== 1'b0) begin
      errors++;
      $display("FAIL paused_new_table: out_o=%b, want 0", out_o);
    end
  endtask

  task automatic test_reset_mid;
    in_i = 4'h5;
    load_cfg(16'hFFFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_out: out_o=%b, want 1", out_o);
    end
    cfg_bit_i = 1'b1;
    cfg_en_i  = 1'b1;
    repeat (9) tick();
    cfg_en_i = 1'b0;
    reset_i  = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (cfg_busy_o !== 1'b0 || out_o !== 1'b0 || cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b out=%b done=%b, want 0 0 0",
               cfg_busy_o, out_o, cfg_done_o);
    end
    load_cfg(16'hA5C3, 1'b0, 1'b0, 1'b0);
    sweep(16'hA5C3, "post_abort");
  endtask

  task automatic test_commit_q;
    // Active A5C3 combinational; in=0 selects bit 0 (1). q was left at 0.
    ce_i = 1'b0;
    in_i = 4'h0;
    load_cfg(16'hFFFF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (out_o !== 1'b0) begin
      errors++;
      $display("FAIL mode_to_reg_q: out_o=%b, want 0", out_o);
    end
    ce_i = 1'b1;
    tick();
    checks++;
    if (out_o !== 1'b1) begin
      errors++;
      $display("FAIL q_track_ffff: out_o=%b, want 1", out_o);
    end
    load_cfg(16'h0000, 1'b1, 1'b0, 1'b1);
    checks++;
    if (out_o !== 1'b1) begin
      errors++;
      $display("FAIL commit_old_q: out_o=%b, want 1", out_o);
    end
    tick();
    checks++;
    if (out_o !== 1'b0 || cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL commit_new_q: out=%b done=%b, want 0 0", out_o, cfg_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_and4();
    test_xor_reg();
    test_paused_load();
    test_reset_mid();
    test_commit_q();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule
